// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and helpers for the operand-forwarding / load-use hazard unit.
package fwd_pkg;

  localparam int REG_AW_DEF = 5;

  localparam int STG_EX = 0;
  localparam int STG_MA = 1;
  localparam int STG_WB = 2;

  // Bit position of (source s, stage k) inside the flattened one-hot select.
  function automatic int unsigned sel_idx(input int unsigned s,
                                          input int unsigned k,
                                          input int unsigned nfwd);
    return s * nfwd + k;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage compare inputs and EX-stage forwarding outputs of the hazard unit.
interface fwd_hazard_unit_if
  import fwd_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter int NFWD   = 3,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
);

  logic [NSRC*REG_AW-1:0] src_adr;
  logic [NSRC-1:0]        src_valid;
  logic [NFWD*REG_AW-1:0] dst_adr;
  logic [NFWD-1:0]        dst_wen;
  logic [NFWD-1:0]        dst_rdy;
  logic                   jmp_purge;
  logic                   stall;
  logic                   rst_pipe;

  logic [NSRC*NFWD-1:0]   fwd_sel_ex;
  logic [NSRC-1:0]        nohit_ex;
  logic                   stall_hz;
  logic                   stall_hz_ex;
  logic                   stall_hz_ex_dly;
  logic [CNT_W-1:0]       stall_cnt;

  modport master (
    output src_adr, src_valid, dst_adr, dst_wen, dst_rdy, jmp_purge, stall, rst_pipe,
    input  fwd_sel_ex, nohit_ex, stall_hz, stall_hz_ex, stall_hz_ex_dly, stall_cnt
  );

  modport slave (
    input  src_adr, src_valid, dst_adr, dst_wen, dst_rdy, jmp_purge, stall, rst_pipe,
    output fwd_sel_ex, nohit_ex, stall_hz, stall_hz_ex, stall_hz_ex_dly, stall_cnt
  );

endinterface

// File: rtl/fwd_hazard_unit_match.sv
// Per-source comparator bank: finds the youngest writing producer and decides
// between forwarding it and flagging a not-ready hazard.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int NFWD   = 3,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0]      src_adr,
  input  logic                   src_valid,
  input  logic [NFWD*REG_AW-1:0] dst_adr,
  input  logic [NFWD-1:0]        dst_wen,
  input  logic [NFWD-1:0]        dst_rdy,
  input  logic                   mask_ex,
  output logic [NFWD-1:0]        sel,
  output logic                   nohit,
  output logic                   hazard
);

  logic [NFWD-1:0] raw;

  always_comb begin
    raw = '0;
    for (int k = 0; k < NFWD; k++) begin
      raw[k] = (dst_adr[k*REG_AW +: REG_AW] != '0) &&
               (dst_adr[k*REG_AW +: REG_AW] == src_adr) &&
               src_valid && dst_wen[k] &&
               !((k == STG_EX) && mask_ex);
    end
  end

  // Walk from oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel    = '0;
    nohit  = 1'b1;
    hazard = 1'b0;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (raw[k]) begin
        sel    = '0;
        sel[k] = dst_rdy[k];
        nohit  = 1'b0;
        hazard = ~dst_rdy[k];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard unit at the ID->EX boundary: one
// comparator bank per source, EX-side select registers and a stall counter.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter int NFWD   = 3,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  fwd_hazard_unit_if.slave  bus
);

  logic [NSRC*NFWD-1:0] sel_vec;
  logic [NSRC-1:0]      nohit_vec;
  logic [NSRC-1:0]      haz_vec;
  logic                 stall_hz;

  logic [NSRC*NFWD-1:0] fwd_sel_q;
  logic [NSRC-1:0]      nohit_q;
  logic [NSRC-1:0]      hz_dly_q;
  logic                 stall_hz_ex_q;
  logic                 stall_hz_ex_dly_q;
  logic [CNT_W-1:0]     stall_cnt_q;

  // Stage 0 holds a bubble after any stall, or after this source's own hazard.
  for (genvar s = 0; s < NSRC; s++) begin : g_src
    fwd_match #(
      .NFWD   (NFWD),
      .REG_AW (REG_AW)
    ) u_match (
      .src_adr   (bus.src_adr[s*REG_AW +: REG_AW]),
      .src_valid (bus.src_valid[s]),
      .dst_adr   (bus.dst_adr),
      .dst_wen   (bus.dst_wen),
      .dst_rdy   (bus.dst_rdy),
      .mask_ex   (stall_hz_ex_q | hz_dly_q[s]),
      .sel       (sel_vec[sel_idx(s, 0, NFWD) +: NFWD]),
      .nohit     (nohit_vec[s]),
      .hazard    (haz_vec[s])
    );
  end

  assign stall_hz = (|haz_vec) & ~bus.jmp_purge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_sel_q         <= '0;
      nohit_q           <= '0;
      hz_dly_q          <= '0;
      stall_hz_ex_q     <= 1'b0;
      stall_hz_ex_dly_q <= 1'b0;
      stall_cnt_q       <= '0;
    end else if (bus.rst_pipe) begin
      fwd_sel_q         <= '0;
      nohit_q           <= '0;
      hz_dly_q          <= '0;
      stall_hz_ex_q     <= 1'b0;
      stall_hz_ex_dly_q <= 1'b0;
      stall_cnt_q       <= '0;
    end else if (!bus.stall) begin
      fwd_sel_q         <= sel_vec;
      nohit_q           <= nohit_vec;
      hz_dly_q          <= haz_vec;
      stall_hz_ex_q     <= stall_hz;
      stall_hz_ex_dly_q <= stall_hz_ex_q;
      if (stall_hz && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.fwd_sel_ex      = fwd_sel_q;
  assign bus.nohit_ex        = nohit_q;
  assign bus.stall_hz        = stall_hz;
  assign bus.stall_hz_ex     = stall_hz_ex_q;
  assign bus.stall_hz_ex_dly = stall_hz_ex_dly_q;
  assign bus.stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed plus random bench for fwd_hazard_unit against a behavioural
// forwarding model; uses a 4-bit counter so saturation is reachable.
module tb_fwd_hazard_unit;

  localparam int NSRC   = 2;
  localparam int NFWD   = 3;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.NSRC(NSRC), .NFWD(NFWD), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

  fwd_hazard_unit #(.NSRC(NSRC), .NFWD(NFWD), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model view of the EX-side registers.
  logic [NSRC*NFWD-1:0] m_sel;
  logic [NSRC-1:0]      m_nohit;
  logic [NSRC-1:0]      m_hzdly;
  logic                 m_shex;
  logic                 m_shdly;
  int                   m_cnt;

  // Model results for the inputs currently applied in ID.
  logic [NSRC*NFWD-1:0] c_sel;
  logic [NSRC-1:0]      c_nohit;
  logic [NSRC-1:0]      c_haz;
  logic                 c_stall;

  function automatic logic [NSRC*REG_AW-1:0] s2(input int a0, input int a1);
    logic [31:0] x0, x1;
    x0 = 32'(a0);
    x1 = 32'(a1);
    return {x1[REG_AW-1:0], x0[REG_AW-1:0]};
  endfunction

  function automatic logic [NFWD*REG_AW-1:0] d3(input int a0, input int a1, input int a2);
    logic [31:0] x0, x1, x2;
    x0 = 32'(a0);
    x1 = 32'(a1);
    x2 = 32'(a2);
    return {x2[REG_AW-1:0], x1[REG_AW-1:0], x0[REG_AW-1:0]};
  endfunction

  // For each source pick the youngest eligible writer of the same nonzero register.
  function automatic void model_comb();
    int best;
    int src, dst;
    c_sel   = '0;
    c_nohit = '0;
    c_haz   = '0;
    for (int s = 0; s < NSRC; s++) begin
      best = -1;
      src  = int'(bus.src_adr[s*REG_AW +: REG_AW]);
      for (int k = 0; k < NFWD; k++) begin
        dst = int'(bus.dst_adr[k*REG_AW +: REG_AW]);
        if (best < 0 && !(k == 0 && (m_shex || m_hzdly[s])) &&
            dst != 0 && dst == src && bus.src_valid[s] && bus.dst_wen[k])
          best = k;
      end
      c_nohit[s] = (best < 0);
      if (best >= 0) begin
        if (bus.dst_rdy[best]) c_sel[s*NFWD + best] = 1'b1;
        else                   c_haz[s] = 1'b1;
      end
    end
    c_stall = (c_haz != '0) && !bus.jmp_purge;
  endfunction

  function automatic void model_clock();
    if (bus.rst_pipe) begin
      m_sel = '0; m_nohit = '0; m_hzdly = '0; m_shex = 1'b0; m_shdly = 1'b0; m_cnt = 0;
    end else if (!bus.stall) begin
      m_shdly = m_shex;
      m_shex  = c_stall;
      m_sel   = c_sel;
      m_nohit = c_nohit;
      m_hzdly = c_haz;
      if (c_stall && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, ".fwd_sel_ex"},      32'(bus.fwd_sel_ex),      32'(m_sel));
    checkOutput({tag, ".nohit_ex"},        32'(bus.nohit_ex),        32'(m_nohit));
    checkOutput({tag, ".stall_hz_ex"},     32'(bus.stall_hz_ex),     32'(m_shex));
    checkOutput({tag, ".stall_hz_ex_dly"}, 32'(bus.stall_hz_ex_dly), 32'(m_shdly));
    checkOutput({tag, ".stall_cnt"},       32'(bus.stall_cnt),       32'(m_cnt));
  endtask

  // One ID cycle: drive, check the combinational request, clock, check EX registers.
  task automatic applyStimulus(input string tag,
                               input logic [NSRC*REG_AW-1:0] src, input logic [NSRC-1:0] sv,
                               input logic [NFWD*REG_AW-1:0] dst, input logic [NFWD-1:0] wen,
                               input logic [NFWD-1:0] rdy,
                               input logic jp, input logic st, input logic rp);
    bus.src_adr   = src;
    bus.src_valid = sv;
    bus.dst_adr   = dst;
    bus.dst_wen   = wen;
    bus.dst_rdy   = rdy;
    bus.jmp_purge = jp;
    bus.stall     = st;
    bus.rst_pipe  = rp;
    #1;
    model_comb();
    checkOutput({tag, ".stall_hz"}, 32'(bus.stall_hz), 32'(c_stall));
    @(posedge clk);
    model_clock();
    #1;
    checkRegs(tag);
  endtask

  initial begin
    m_sel = '0; m_nohit = '0; m_hzdly = '0; m_shex = 1'b0; m_shdly = 1'b0; m_cnt = 0;
    rst_n = 1'b0;
    bus.src_adr = '0; bus.src_valid = '0; bus.dst_adr = '0; bus.dst_wen = '0;
    bus.dst_rdy = '0; bus.jmp_purge = 1'b0; bus.stall = 1'b0; bus.rst_pipe = 1'b0;
    #12;
    checkRegs("reset");
    rst_n = 1'b1;

    // ALU-to-ALU at EX, then dual match where the youngest wins.
    applyStimulus("alu_ex", s2(5, 0), 2'b01, d3(5, 0, 0), 3'b001, 3'b111, 1'b0, 1'b0, 1'b0);
    checkOutput("alu_ex.sel_bit0", 32'(bus.fwd_sel_ex), 32'h01);
    applyStimulus("dual", s2(0, 7), 2'b10, d3(7, 0, 7), 3'b101, 3'b111, 1'b0, 1'b0, 1'b0);
    checkOutput("dual.sel_bit3", 32'(bus.fwd_sel_ex), 32'h08);

    // Load-use: stall one cycle, then forward from stage 1 with stage 0 masked.
    applyStimulus("load0", s2(3, 0), 2'b01, d3(3, 0, 0), 3'b001, 3'b110, 1'b0, 1'b0, 1'b0);
    checkOutput("load0.cnt1", 32'(bus.stall_cnt), 32'd1);
    applyStimulus("load1", s2(3, 0), 2'b01, d3(3, 3, 0), 3'b011, 3'b010, 1'b0, 1'b0, 1'b0);
    checkOutput("load1.sel_bit1", 32'(bus.fwd_sel_ex), 32'h02);
    applyStimulus("idle", s2(0, 0), 2'b00, d3(0, 0, 0), 3'b000, 3'b111, 1'b0, 1'b0, 1'b0);

    // x0 and unread sources never hit.
    applyStimulus("x0", s2(0, 0), 2'b11, d3(0, 0, 0), 3'b111, 3'b000, 1'b0, 1'b0, 1'b0);
    checkOutput("x0.nohit", 32'(bus.nohit_ex), 32'h3);
    applyStimulus("novalid", s2(4, 4), 2'b00, d3(4, 4, 4), 3'b111, 3'b000, 1'b0, 1'b0, 1'b0);

    // Jump purge suppresses the request; the source's own flag still masks stage 0.
    applyStimulus("purge", s2(6, 0), 2'b01, d3(6, 0, 0), 3'b001, 3'b110, 1'b1, 1'b0, 1'b0);
    applyStimulus("purge_after", s2(6, 0), 2'b01, d3(6, 6, 0), 3'b011, 3'b111, 1'b0, 1'b0, 1'b0);

    // Global stall holds every register.
    applyStimulus("hold", s2(2, 2), 2'b11, d3(2, 0, 0), 3'b001, 3'b111, 1'b0, 1'b1, 1'b0);

    // Multi-cycle producer in stage 1 stalls every cycle and saturates the counter.
    for (int i = 0; i < 20; i++)
      applyStimulus("sat", s2(9, 0), 2'b01, d3(0, 9, 0), 3'b010, 3'b101, 1'b0, 1'b0, 1'b0);
    checkOutput("sat.cnt15", 32'(bus.stall_cnt), 32'd15);
    applyStimulus("rst_pipe", s2(9, 0), 2'b01, d3(0, 9, 0), 3'b010, 3'b101, 1'b0, 1'b0, 1'b1);
    applyStimulus("post_clear", s2(9, 0), 2'b01, d3(9, 0, 0), 3'b001, 3'b111, 1'b0, 1'b0, 1'b0);
    checkOutput("post_clear.sel_bit0", 32'(bus.fwd_sel_ex), 32'h01);

    // Random traffic over a small register set to provoke frequent matches.
    for (int i = 0; i < 300; i++) begin
      applyStimulus("rand",
                    s2(int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
                    2'($urandom_range(0, 3)),
                    d3(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3))),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
